partition_err_monitor: RTL and testbench
========================================

PARTITION_ERR_MONITOR -- requirements
Module: partition_err_monitor

Interface
REQ-001 The block SHALL have parameter IN_W, default 7: input vector width of the partition under test.
REQ-002 The block SHALL have parameter OUT_W, default 4: output width of the partition under test.
REQ-003 The block SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1: synchronous active-low reset, sampled on rising edge of clk.
REQ-005 The block SHALL have port start, input, 1: begin exhaustive sweep; honoured only in IDLE or DONE.
REQ-006 The block SHALL have ports vec_o (output, IN_W) and vec_valid (output, 1): stimulus vector and its qualifier, driven to both exact and approximate partitions.
REQ-007 The block SHALL have port vec_ready, input, 1: stimulus accepted when vec_valid && vec_ready.
REQ-008 The block SHALL have ports resp_valid (input, 1), exact_i (input, OUT_W) and approx_i (input, OUT_W): response pair for the last accepted vector.
REQ-009 The block SHALL have ports busy (output, 1) and done (output, 1): sweep in progress; sweep complete with results stable.
REQ-010 The block SHALL have port err_cnt, output, IN_W+1: number of vectors where exact_i != approx_i.
REQ-011 The block SHALL have port ham_sum, output, IN_W+$clog2(OUT_W+1): total bit-flip (Hamming) distance over the sweep.
REQ-012 The block SHALL have port max_abs_err, output, OUT_W: maximum |exact_i - approx_i|, unsigned operands.

Function
REQ-013 FSM SHALL have states IDLE, ISSUE, WAIT, DONE.
- IDLE->ISSUE on start.
- ISSUE->WAIT on vec_valid && vec_ready.
- WAIT->ISSUE on resp_valid when vector != 2^IN_W-1.
- WAIT->DONE on resp_valid when vector == 2^IN_W-1.
- DONE->ISSUE on start.
REQ-014 On start, accumulators and vector SHALL clear to 0 in the same edge that enters ISSUE.
REQ-015 vec_valid SHALL be 1 only in ISSUE; vec_o SHALL hold stable while vec_valid && !vec_ready.
REQ-016 Vectors SHALL be issued in ascending order 0..2^IN_W-1, exactly once each, with at most one outstanding.
REQ-017 resp_valid outside WAIT SHALL be ignored; in WAIT, the response SHALL be accumulated in the edge it is sampled.
REQ-018 err_cnt SHALL increment by 1 per mismatching pair; ham_sum SHALL add popcount(exact_i ^ approx_i).
REQ-019 Accumulator widths SHALL hold full-sweep maxima without wrap: err_cnt max 2^IN_W, ham_sum max OUT_W*2^IN_W.
REQ-020 Vector counter SHALL NOT wrap mid-sweep; the terminal vector is detected before increment.
REQ-021 busy SHALL be 1 in ISSUE and WAIT; done SHALL be 1 in DONE only.
REQ-022 Results SHALL hold from DONE until the next start edge.
REQ-023 start asserted in ISSUE or WAIT SHALL be ignored.
REQ-024 Minimum sweep latency SHALL be 2 cycles per vector (vec_ready and resp_valid both tied high): 2^(IN_W+1) cycles from start to done.

Reset
REQ-025 On rst_n low, the block SHALL enter IDLE with vec_o=0, vec_valid=0, busy=0, done=0, err_cnt=0, ham_sum=0, max_abs_err=0.
REQ-026 Reset asserted mid-sweep SHALL abort the sweep, discarding partial results; no vec_valid SHALL appear until a new start.

Configuration
REQ-027 Macro PARTITION_MAXERR_EN SHALL control max-error tracking.
- Defined: max_abs_err updates to max(current, |exact_i - approx_i|) per accepted response.
- Undefined: max_abs_err is constant 0 and no subtractor/comparator is synthesised.

Verification
REQ-028 Sweep with approx_i = exact_i = vec_o[3:0] + vec_o[6:4], handshakes tied high -> done after 256 cycles, err_cnt=0, ham_sum=0, max_abs_err=0.
REQ-029 approx_i = exact_i ^ 4'b0001 for all vectors -> err_cnt=128, ham_sum=128, max_abs_err=1 (with macro).
REQ-030 approx_i = 0 and exact_i = 4'b1111 for vector 127 only, else equal -> err_cnt=1, ham_sum=4, max_abs_err=15 (with macro), 0 (without).
REQ-031 vec_ready low for 3 cycles on vector 5 -> vec_o holds 5 with vec_valid=1 for 4 cycles; final results unchanged vs REQ-028.
REQ-032 rst_n low for 1 cycle while in WAIT on vector 40, then start -> all outputs 0 after reset; new sweep begins at vector 0.
REQ-033 Spurious resp_valid in ISSUE and in IDLE -> no accumulator change; start pulsed during WAIT -> sweep continues without restart.

Source files
------------

// File: rtl/partition_err_monitor.sv
// Exhaustive 0..2^IN_W-1 sweep comparing exact vs approximate partition outputs; 2 cycles/vector minimum, one vector outstanding.
// vec_o holds while vec_valid && !vec_ready; PARTITION_MAXERR_EN enables max_abs_err tracking (else constant 0).
module partition_err_monitor #(
  parameter int IN_W  = 7,
  parameter int OUT_W = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  output logic [IN_W-1:0]                   vec_o,
  output logic                              vec_valid,
  input  logic                              vec_ready,
  input  logic                              resp_valid,
  input  logic [OUT_W-1:0]                  exact_i,
  input  logic [OUT_W-1:0]                  approx_i,
  output logic                              busy,
  output logic                              done,
  output logic [IN_W:0]                     err_cnt,
  output logic [IN_W+$clog2(OUT_W+1)-1:0]   ham_sum,
  output logic [OUT_W-1:0]                  max_abs_err
);
  localparam int PC_W  = $clog2(OUT_W + 1);
  localparam int HAM_W = IN_W + PC_W;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic [IN_W-1:0]   vec_q, vec_d;
  logic [IN_W:0]     err_cnt_q, err_cnt_d;
  logic [HAM_W-1:0]  ham_sum_q, ham_sum_d;
  logic [OUT_W-1:0]  diff;
  logic [PC_W-1:0]   popcnt;
  logic              clear;
  logic              accept;

  assign diff   = exact_i ^ approx_i;
  assign clear  = start && ((state_q == IDLE) || (state_q == DONE));
  assign accept = (state_q == WAIT) && resp_valid;

  always_comb begin
    popcnt = '0;
    for (int i = 0; i < OUT_W; i++) begin
      popcnt = popcnt + PC_W'(diff[i]);
    end
  end

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    err_cnt_d = err_cnt_q;
    ham_sum_d = ham_sum_q;
    vec_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        done = (state_q == DONE);
        if (clear) begin
          state_d   = ISSUE;
          vec_d     = '0;
          err_cnt_d = '0;
          ham_sum_d = '0;
        end
      end
      ISSUE: begin
        vec_valid = 1'b1;
        busy      = 1'b1;
        if (vec_ready) state_d = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (accept) begin
          if (diff != '0) err_cnt_d = err_cnt_q + (IN_W+1)'(1);
          ham_sum_d = ham_sum_q + HAM_W'(popcnt);
          // Terminal vector is caught before increment so the counter never wraps.
          if (vec_q == '1) begin
            state_d = DONE;
          end else begin
            vec_d   = vec_q + IN_W'(1);
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      vec_q     <= '0;
      err_cnt_q <= '0;
      ham_sum_q <= '0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      err_cnt_q <= err_cnt_d;
      ham_sum_q <= ham_sum_d;
    end
  end

  assign vec_o   = vec_q;
  assign err_cnt = err_cnt_q;
  assign ham_sum = ham_sum_q;

`ifdef PARTITION_MAXERR_EN
  logic [OUT_W-1:0] max_q, max_d, abs_err;

  always_comb begin
    abs_err = (exact_i >= approx_i) ? (exact_i - approx_i) : (approx_i - exact_i);
    max_d   = max_q;
    if (clear) begin
      max_d = '0;
    end else if (accept && (abs_err > max_q)) begin
      max_d = abs_err;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) max_q <= '0;
    else        max_q <= max_d;
  end

  assign max_abs_err = max_q;
`else
  assign max_abs_err = '0;
`endif

endmodule

// File: tb/tb_partition_err_monitor.sv
// Bench for partition_err_monitor: transaction-count model plus directed sweeps with literal end-of-sweep expectations.
module tb_partition_err_monitor;
  localparam int NV = 128;
`ifdef PARTITION_MAXERR_EN
  localparam bit MAXEN = 1'b1;
`else
  localparam bit MAXEN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, start, vec_ready, resp_valid;
  logic [6:0] vec_o;
  logic       vec_valid, busy, done;
  logic [3:0] exact_i, approx_i, max_abs_err;
  logic [7:0] err_cnt;
  logic [9:0] ham_sum;
  int         mode = 0;
  int         tests = 0;
  int         failed = 0;

  always #5 clk = ~clk;

  partition_err_monitor dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .vec_o(vec_o), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .resp_valid(resp_valid), .exact_i(exact_i), .approx_i(approx_i),
    .busy(busy), .done(done), .err_cnt(err_cnt), .ham_sum(ham_sum),
    .max_abs_err(max_abs_err)
  );

  function automatic logic [3:0] f_exact(input int md, input logic [6:0] v);
    logic [3:0] b;
    b = 4'(v[3:0] + {1'b0, v[6:4]});
    if (md == 2 && v == 7'd127) return 4'hF;
    return b;
  endfunction

  function automatic logic [3:0] f_approx(input int md, input logic [6:0] v);
    logic [3:0] b;
    b = f_exact(md, v);
    if (md == 1) return b ^ 4'b0001;
    if (md == 2 && v == 7'd127) return 4'h0;
    return b;
  endfunction

  // Partition under test reacts to whatever vector the monitor presents.
  assign exact_i  = f_exact(mode, vec_o);
  assign approx_i = f_approx(mode, vec_o);

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: count handshakes and responses within the current sweep.
  bit m_run = 0;
  int m_iss = 0, m_resp = 0, m_err = 0, m_ham = 0, m_max = 0;

  always @(posedge clk) begin
    int ie, ia, d;
    if (!rst_n) begin
      m_run = 0; m_iss = 0; m_resp = 0; m_err = 0; m_ham = 0; m_max = 0;
    end else if (start && !(m_run && m_resp < NV)) begin
      m_run = 1; m_iss = 0; m_resp = 0; m_err = 0; m_ham = 0; m_max = 0;
    end else if (m_run && m_resp < NV) begin
      if (m_iss == m_resp) begin
        if (vec_ready) m_iss++;
      end else if (resp_valid) begin
        ie = int'(f_exact(mode, 7'(m_resp)));
        ia = int'(f_approx(mode, 7'(m_resp)));
        if (ie != ia) m_err++;
        m_ham += $countones(7'(ie ^ ia));
        d = (ie > ia) ? ie - ia : ia - ie;
        if (d > m_max) m_max = d;
        m_resp++;
      end
    end
  end

  always @(negedge clk) begin
    bit e_busy;
    int e_vec;
    e_busy = m_run && (m_resp < NV);
    e_vec  = !m_run ? 0 : (m_resp == NV ? NV - 1 : m_resp);
    chk("busy", int'(busy), int'(e_busy));
    chk("done", int'(done), int'(m_run && m_resp == NV));
    chk("vec_valid", int'(vec_valid), int'(e_busy && m_iss == m_resp));
    chk("vec_o", int'(vec_o), e_vec);
    chk("err_cnt", int'(err_cnt), m_err);
    chk("ham_sum", int'(ham_sum), m_ham);
    chk("max_abs_err", int'(max_abs_err), MAXEN ? m_max : 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep(input int md, input bit stall, input bit rpat, input bit abort,
                       output int cyc, output int hold);
    int stl;
    stl  = 0;
    hold = 0;
    cyc  = 0;
    mode = md;
    vec_ready = 1'b1; resp_valid = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (!done && cyc < 3000) begin
      vec_ready = 1'b1; resp_valid = 1'b1; start = 1'b0;
      if (stall && vec_valid && vec_o == 7'd5) begin
        hold++;
        if (stl < 3) begin vec_ready = 1'b0; stl++; end
      end
      if (rpat) begin
        resp_valid = (cyc % 3 != 1);
        if (cyc >= 40 && cyc < 44) start = 1'b1;
      end
      if (abort && busy && !vec_valid && vec_o == 7'd40) rst_n = 1'b0;
      tick();
      cyc++;
      if (!rst_n) begin
        rst_n = 1'b1;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic chk_results(input string tag, input int e_err, input int e_ham, input int e_max);
    chk({tag, "_done"}, int'(done), 1);
    chk({tag, "_err"}, int'(err_cnt), e_err);
    chk({tag, "_ham"}, int'(ham_sum), e_ham);
    chk({tag, "_max"}, int'(max_abs_err), e_max);
  endtask

  initial begin
    int cyc, hold;
    rst_n = 1'b0; start = 1'b0; vec_ready = 1'b1; resp_valid = 1'b0;
    tick(); tick();
    chk("rst_vec_valid", int'(vec_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err_cnt), 0);
    chk("rst_vec", int'(vec_o), 0);
    rst_n = 1'b1;

    mode = 1; resp_valid = 1'b1;
    repeat (4) tick();
    chk("idle_spurious_err", int'(err_cnt), 0);
    chk("idle_spurious_ham", int'(ham_sum), 0);

    sweep(0, 0, 0, 0, cyc, hold);
    chk("exact_latency", cyc, 256);
    chk_results("exact", 0, 0, 0);

    sweep(1, 0, 0, 0, cyc, hold);
    chk("lsb_latency", cyc, 256);
    chk_results("lsb", 128, 128, MAXEN ? 1 : 0);
    mode = 2; resp_valid = 1'b1;
    repeat (5) tick();
    chk_results("hold", 128, 128, MAXEN ? 1 : 0);

    sweep(2, 0, 0, 0, cyc, hold);
    chk_results("v127", 1, 4, MAXEN ? 15 : 0);

    sweep(0, 1, 0, 0, cyc, hold);
    chk("stall_hold", hold, 4);
    chk("stall_latency", cyc, 259);
    chk_results("stall", 0, 0, 0);

    sweep(1, 0, 1, 0, cyc, hold);
    chk_results("rpat", 128, 128, MAXEN ? 1 : 0);

    sweep(1, 0, 0, 1, cyc, hold);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_err", int'(err_cnt), 0);
    chk("abort_ham", int'(ham_sum), 0);
    chk("abort_vec", int'(vec_o), 0);
    repeat (3) begin
      tick();
      chk("abort_no_valid", int'(vec_valid), 0);
    end
    sweep(0, 0, 0, 0, cyc, hold);
    chk("post_abort_latency", cyc, 256);
    chk_results("post_abort", 0, 0, 0);

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
